// File: rtl/axil_dna_reader_pkg.sv
// Shared constants and types for the AXI4-Lite DNA reader.
package axil_dna_reader_pkg;

  // Byte offsets of the DNA slave registers relative to its base address.
  localparam logic [7:0] REG_DNA0_OFS   = 8'h00;
  localparam logic [7:0] REG_DNA1_OFS   = 8'h04;
  localparam logic [7:0] REG_DNA2_OFS   = 8'h08;
  localparam logic [7:0] REG_FAMILY_OFS = 8'h0C;

  // Family codes reported in register 3.
  localparam logic [31:0] FAMILY_7SERIES    = 32'd7;
  localparam logic [31:0] FAMILY_ULTRASCALE = 32'd2;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StCheck,
    StGap,
    StDone,
    StErr
  } state_e;

  // Register index to byte offset.
  function automatic logic [7:0] reg_offset(input logic [1:0] idx);
    logic [7:0] ofs;
    unique case (idx)
      2'd0:    ofs = REG_DNA0_OFS;
      2'd1:    ofs = REG_DNA1_OFS;
      2'd2:    ofs = REG_DNA2_OFS;
      default: ofs = REG_FAMILY_OFS;
    endcase
    return ofs;
  endfunction

  function automatic logic family_ok(input logic [31:0] fam);
    return (fam == FAMILY_7SERIES) || (fam == FAMILY_ULTRASCALE);
  endfunction

endpackage

// File: rtl/axil_dna_reader_if.sv
// AXI4-Lite bus bundle between the DNA reader (master) and the DNA slave.
interface axil_dna_reader_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);

  // Read address / data channels
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  // Write channels, unused by the reader but present on the bus
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arprot, arvalid, rready,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axil_dna_reader.sv
// Reads the four DNA slave registers over AXI4-Lite, polls until the DNA is
// non-zero, validates the family code and holds the 96-bit result.
module axil_dna_reader
  import axil_dna_reader_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0000,
  parameter int unsigned           AUTO_START = 1,
  parameter int unsigned           POLL_LIMIT = 16,
  parameter int unsigned           POLL_GAP   = 64
) (
  input  logic                 m_axil_clk,
  input  logic                 m_axil_rstn,
  input  logic                 start,
  output logic                 busy,
  output logic                 dna_valid,
  output logic                 dna_error,
  output logic [95:0]          dna,
  output logic [31:0]          family,
  axil_dna_reader_if.master    m_axil
);

  localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_e                      state_q, state_d;
  logic [1:0]                  idx_q, idx_d;
  logic [7:0]                  pass_q, pass_d;
  logic [GapW-1:0]             gap_q, gap_d;
  logic [3:0][DATA_WIDTH-1:0]  word_q, word_d;
  logic [95:0]                 dna_q, dna_d;
  logic [31:0]                 family_q, family_d;
  logic                        first_q;
  logic                        go;
  logic                        unused_bus;

  // Write-channel responses are never looked at.
  assign unused_bus = ^{m_axil.awready, m_axil.wready, m_axil.bresp, m_axil.bvalid};

  // First cycle after reset release stands in for a start pulse when enabled.
  assign go = start || ((AUTO_START != 0) && first_q);

  // State and datapath registers.
  always_ff @(posedge m_axil_clk or negedge m_axil_rstn) begin
    if (!m_axil_rstn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      pass_q   <= '0;
      gap_q    <= '0;
      word_q   <= '0;
      dna_q    <= '0;
      family_q <= '0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      gap_q    <= gap_d;
      word_q   <= word_d;
      dna_q    <= dna_d;
      family_q <= family_d;
      first_q  <= 1'b0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    gap_d    = gap_q;
    word_d   = word_q;
    dna_d    = dna_q;
    family_d = family_q;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (go) begin
          state_d = StAr;
          idx_d   = '0;
          pass_d  = '0;
        end
      end

      StAr: begin
        if (m_axil.arready) state_d = StR;
      end

      StR: begin
        if (m_axil.rvalid) begin
          word_d[idx_q] = m_axil.rdata;
          if (m_axil.rresp != RESP_OKAY) begin
            // Expose whatever has been captured so far.
            state_d  = StErr;
            dna_d    = word_d[2:0];
            family_d = word_d[3];
          end else if (idx_q == 2'd3) begin
            state_d = StCheck;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StAr;
          end
        end
      end

      StCheck: begin
        if (word_q[2:0] == '0) begin
          // Slave has not produced the DNA yet: retry after a gap.
          pass_d = pass_q + 8'd1;
          if (pass_d == 8'(POLL_LIMIT)) begin
            state_d  = StErr;
            dna_d    = word_q[2:0];
            family_d = word_q[3];
          end else begin
            state_d = StGap;
            gap_d   = '0;
          end
        end else begin
          state_d  = family_ok(word_q[3]) ? StDone : StErr;
          dna_d    = word_q[2:0];
          family_d = word_q[3];
        end
      end

      StGap: begin
        if (gap_q == GapW'(POLL_GAP - 1)) begin
          state_d = StAr;
          idx_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy           = (state_q == StAr) || (state_q == StR) ||
                     (state_q == StCheck) || (state_q == StGap);
    dna_valid      = (state_q == StDone);
    dna_error      = (state_q == StErr);
    m_axil.arvalid = (state_q == StAr);
    m_axil.rready  = (state_q == StR);
    m_axil.araddr  = BASE_ADDR + ADDR_WIDTH'(reg_offset(idx_q));
    m_axil.arprot  = 3'b000;
    m_axil.awaddr  = '0;
    m_axil.awprot  = 3'b000;
    m_axil.awvalid = 1'b0;
    m_axil.wdata   = '0;
    m_axil.wstrb   = '0;
    m_axil.wvalid  = 1'b0;
    m_axil.bready  = 1'b1;
  end

  assign dna    = dna_q;
  assign family = family_q;

endmodule
